// File: rtl/kyber_pkg.sv
// Shared Kyber constants, polynomial sizing helper and the byte-encoder state type.
package kyber_pkg;

  localparam int KYBER_N = 256;
  localparam int KYBER_Q = 3329;

  typedef enum logic {ACCEPT, FLUSH} enc_state_t;

  function automatic int poly_bytes(input int d);
    return 32 * d;
  endfunction

endpackage

// File: rtl/byte_encode.sv
// Packs D-bit coefficients LSB-first into bytes; a completed byte is presented the cycle after
// the coefficient that finishes it. in_ready depends only on registered fill, never on out_ready.
module byte_encode
  import kyber_pkg::*;
#(
  parameter int D      = 10,
  parameter int N_COEF = KYBER_N,
  parameter int BUF_W  = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [D-1:0] in_coef,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_byte,
  output logic         out_last
);

  localparam int NBYTES = poly_bytes(D);
  localparam int CW     = (N_COEF > 1) ? $clog2(N_COEF) : 1;
  localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int FW     = $clog2(BUF_W + 1);

  enc_state_t       state_q, state_d;
  logic [BUF_W-1:0] acc_q, acc_d, acc_sh;
  logic [FW-1:0]    fill_q, fill_d, fill_sh;
  logic [CW-1:0]    coef_cnt_q, coef_cnt_d;
  logic [BW-1:0]    byte_cnt_q, byte_cnt_d;
  logic             in_fire, out_fire, last_coef, last_byte;

  assign out_valid = (fill_q >= FW'(8));
  assign out_byte  = acc_q[7:0];
  assign last_byte = (byte_cnt_q == BW'(NBYTES - 1));
  assign out_last  = out_valid && last_byte;
  assign in_ready  = (state_q == ACCEPT) && ((int'(fill_q) + D) <= BUF_W);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign last_coef = (coef_cnt_q == CW'(N_COEF - 1));

  always_comb begin
    acc_sh     = acc_q;
    fill_sh    = fill_q;
    state_d    = state_q;
    coef_cnt_d = coef_cnt_q;
    byte_cnt_d = byte_cnt_q;

    // Drain first so a new coefficient lands directly above the bits that remain.
    if (out_fire) begin
      acc_sh     = acc_q >> 8;
      fill_sh    = fill_q - FW'(8);
      byte_cnt_d = last_byte ? '0 : byte_cnt_q + BW'(1);
    end

    acc_d  = acc_sh;
    fill_d = fill_sh;
    if (in_fire) begin
      acc_d  = acc_sh | (BUF_W'(in_coef) << fill_sh);
      fill_d = fill_sh + FW'(D);
      if (!last_coef) begin
        coef_cnt_d = coef_cnt_q + CW'(1);
      end
    end

    case (state_q)
      ACCEPT: begin
        if (in_fire && last_coef) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (out_fire && last_byte) begin
          state_d    = ACCEPT;
          coef_cnt_d = '0;
          acc_d      = '0;
          fill_d     = '0;
        end
      end
      default: state_d = ACCEPT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACCEPT;
      acc_q      <= '0;
      fill_q     <= '0;
      coef_cnt_q <= '0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      fill_q     <= fill_d;
      coef_cnt_q <= coef_cnt_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

endmodule

// File: tb/tb_byte_encode.sv
// Scoreboard bench for byte_encode: four instances (D=1,4,10,12) exercised one at a time,
// expected {last,byte} pairs queued at stimulus time and popped by per-instance monitors.
module tb_byte_encode;
  import kyber_pkg::*;

  logic        clk;
  logic        rst;
  logic [3:0]  iv, ir, ov, orr, ol;
  logic [31:0] ob;
  logic [11:0] coef [4];
  int          or_mode [4];

  logic [8:0]  exp_q[$];
  int          n_checks, n_pass;

  longint unsigned m_acc;
  int              m_fill, m_bcnt, m_d;

  logic [11:0] c1  [8] = '{12'd1, 12'd0, 12'd1, 12'd1, 12'd0, 12'd0, 12'd0, 12'd1};
  logic [11:0] c4  [4] = '{12'h3, 12'hA, 12'hF, 12'h0};
  logic [11:0] c10 [4] = '{12'h3FF, 12'h001, 12'h000, 12'h000};
  logic [11:0] c12 [4] = '{12'hABC, 12'h123, 12'h456, 12'h789};

  byte_encode #(.D(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_coef(coef[0][0:0]),
    .out_valid(ov[0]), .out_ready(orr[0]), .out_byte(ob[7:0]), .out_last(ol[0]));
  byte_encode #(.D(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_coef(coef[1][3:0]),
    .out_valid(ov[1]), .out_ready(orr[1]), .out_byte(ob[15:8]), .out_last(ol[1]));
  byte_encode #(.D(10)) u_d10 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_coef(coef[2][9:0]),
    .out_valid(ov[2]), .out_ready(orr[2]), .out_byte(ob[23:16]), .out_last(ol[2]));
  byte_encode #(.D(12)) u_d12 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .in_coef(coef[3][11:0]),
    .out_valid(ov[3]), .out_ready(orr[3]), .out_byte(ob[31:24]), .out_last(ol[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // out_ready per instance: 0 = held low, 1 = held high, 2 = random (75% high)
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 4; k++) begin
      orr[k] = (or_mode[k] == 2) ? ($urandom_range(0, 3) != 0) : (or_mode[k] == 1);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_mon
    always @(negedge clk) begin
      if (!rst && ov[g] && orr[g]) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_byte dut%0d actual=%02h required=none", g, ob[8*g+:8]);
        end else begin
          chk($sformatf("byte_last dut%0d", g), {23'b0, ol[g], ob[8*g+:8]}, {23'b0, exp_q.pop_front()});
        end
      end
    end
  end

  function automatic void model_push(input logic [11:0] c);
    m_acc  = m_acc | (64'(c) << m_fill);
    m_fill = m_fill + m_d;
    while (m_fill >= 8) begin
      exp_q.push_back({(m_bcnt == 32 * m_d - 1), m_acc[7:0]});
      m_bcnt = (m_bcnt == 32 * m_d - 1) ? 0 : m_bcnt + 1;
      m_acc  = m_acc >> 8;
      m_fill = m_fill - 8;
    end
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted the coef.
  task automatic send(input int k, input logic [11:0] c, input bit gaps);
    int t;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    iv[k]   = 1'b1;
    coef[k] = c;
    t = 0;
    @(negedge clk);
    while (!ir[k] && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!ir[k]) begin
      n_checks++;
      $display("FAIL send_timeout dut%0d actual=in_ready_low required=accept", k);
    end
    @(posedge clk);
    #1;
    iv[k] = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 4000) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk({"drain_", name}, exp_q.size(), 0);
  endtask

  task automatic model_reset(input int d, input int bcnt);
    m_d    = d;
    m_acc  = 0;
    m_fill = 0;
    m_bcnt = bcnt;
  endtask

  initial begin
    int  n;
    bit  fire;
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    iv       = '0;
    for (int k = 0; k < 4; k++) begin
      coef[k]    = '0;
      or_mode[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_in_ready%0d", k), ir[k], 1);
      chk($sformatf("rst_out_valid%0d", k), ov[k], 0);
      chk($sformatf("rst_out_byte%0d", k), ob[8*k+:8], 0);
      chk($sformatf("rst_out_last%0d", k), ol[k], 0);
    end
    @(posedge clk);
    #1;

    // D=1: bits 1,0,1,1,0,0,0,1 -> 0x8D
    or_mode[0] = 1;
    exp_q.push_back({1'b0, 8'h8D});
    for (int i = 0; i < 8; i++) send(0, c1[i], 1'b0);
    drain("d1");

    // D=4: 3,A,F,0 -> A3 0F
    or_mode[1] = 1;
    exp_q.push_back({1'b0, 8'hA3});
    exp_q.push_back({1'b0, 8'h0F});
    for (int i = 0; i < 4; i++) send(1, c4[i], 1'b0);
    drain("d4");

    // D=12 with consumer stalled: ABC,123 -> BC 3A 12 ; 456,789 -> 56 94 78
    exp_q.push_back({1'b0, 8'hBC});
    exp_q.push_back({1'b0, 8'h3A});
    exp_q.push_back({1'b0, 8'h12});
    exp_q.push_back({1'b0, 8'h56});
    exp_q.push_back({1'b0, 8'h94});
    exp_q.push_back({1'b0, 8'h78});
    n       = 0;
    iv[3]   = 1'b1;
    coef[3] = c12[0];
    repeat (20) begin
      @(negedge clk);
      fire = ir[3];
      @(posedge clk);
      #1;
      if (fire) begin
        n++;
        if (n < 4) coef[3] = c12[n];
        else iv[3] = 1'b0;
      end
    end
    @(negedge clk);
    chk("d12_accepted_while_stalled", n, 2);
    chk("d12_in_ready_when_full", ir[3], 0);
    chk("d12_out_valid_when_full", ov[3], 1);
    @(posedge clk);
    #1;
    iv[3]      = 1'b0;
    or_mode[3] = 1;
    for (int i = n; i < 4; i++) send(3, c12[i], 1'b0);
    drain("d12");

    // D=10 directed head of a polynomial: 3FF,1,0,0 -> FF 07 00 00 00
    or_mode[2] = 2;
    exp_q.push_back({1'b0, 8'hFF});
    exp_q.push_back({1'b0, 8'h07});
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, 8'h00});
    for (int i = 0; i < 4; i++) send(2, c10[i], 1'b1);
    model_reset(10, 5);
    for (int i = 4; i < 256; i++) begin
      model_push(12'(i % 1024));
      send(2, 12'(i % 1024), 1'b1);
    end
    drain("d10_poly0");

    // Two polynomials back to back, no input gaps
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 256; i++) begin
        model_push(12'(i % 1024));
        send(2, 12'(i % 1024), 1'b0);
      end
    end
    drain("d10_b2b");

    // Reset after 100 coefs of a polynomial, then a fresh polynomial
    for (int i = 0; i < 100; i++) begin
      model_push(12'(i % 1024));
      send(2, 12'(i % 1024), 1'b1);
    end
    repeat (5) @(posedge clk);
    or_mode[2] = 0;
    repeat (3) @(posedge clk);
    #1;
    exp_q.delete();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("d10_post_rst_out_valid", ov[2], 0);
    chk("d10_post_rst_in_ready", ir[2], 1);
    chk("d10_post_rst_out_last", ol[2], 0);
    @(posedge clk);
    #1;
    model_reset(10, 0);
    or_mode[2] = 2;
    for (int i = 0; i < 256; i++) begin
      model_push(12'(i % 1024));
      send(2, 12'(i % 1024), 1'b1);
    end
    drain("d10_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
